// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: host byte-frame parser driving an 8-bit config register bank over uart_rx/uart_tx.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every W/R frame.
module uart_cmd_ctrl #(
  parameter int          NUM_REGS     = 16,
  parameter int          TIMEOUT_CLKS = 16368,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15,
  localparam int         AW           = $clog2(NUM_REGS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_dv_in,
  input  logic [7:0]            rx_data_in,
  output logic                  tx_dv_out,
  output logic [7:0]            tx_data_out,
  input  logic                  tx_active_in,
  input  logic                  tx_done_in,
  output logic [NUM_REGS*8-1:0] cfg_regs_out,
  output logic                  wr_pulse_out,
  output logic [AW-1:0]         wr_addr_out,
  output logic                  busy_out
);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam int         CW    = $clog2(TIMEOUT_CLKS);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    S_CSUM,
`endif
    S_EXEC, S_RESP, S_WAIT
  } state_t;
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, resp_q, resp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          timed_out, frame_ok, is_w;
  state_t        after_body;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  assign frame_ok   = csum_q == (cmd_q ^ addr_q ^ (is_w ? data_q : 8'h00));
  assign after_body = S_CSUM;
`else
  assign frame_ok   = 1'b1;
  assign after_body = S_EXEC;
`endif
  assign is_w      = cmd_q == CMD_W;
  assign timed_out = !rx_dv_in && cnt_q == CW'(TIMEOUT_CLKS - 1);
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_d     = resp_q;
    cnt_d      = '0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    regs_d     = regs_q;
    tx_dv_out  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: if (rx_dv_in) begin
        cmd_d   = rx_data_in;
        state_d = (rx_data_in == CMD_W || rx_data_in == CMD_R) ? S_ADDR : S_RESP;
        resp_d  = NAK_BYTE;
      end
      S_ADDR: begin
        cnt_d   = rx_dv_in ? '0 : cnt_q + CW'(1);
        addr_d  = rx_dv_in ? rx_data_in : addr_q;
        state_d = rx_dv_in ? (is_w ? S_DATA : after_body) : timed_out ? S_IDLE : state_q;
      end
      S_DATA: begin
        cnt_d   = rx_dv_in ? '0 : cnt_q + CW'(1);
        data_d  = rx_dv_in ? rx_data_in : data_q;
        state_d = rx_dv_in ? after_body : timed_out ? S_IDLE : state_q;
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: begin
        cnt_d   = rx_dv_in ? '0 : cnt_q + CW'(1);
        csum_d  = rx_dv_in ? rx_data_in : csum_q;
        state_d = rx_dv_in ? S_EXEC : timed_out ? S_IDLE : state_q;
      end
`endif
      S_EXEC: begin
        state_d = S_RESP;
        if (int'(addr_q) >= NUM_REGS || !frame_ok) resp_d = NAK_BYTE;
        else if (is_w) begin
          regs_d[addr_q[AW-1:0]] = data_q;
          wr_pulse_d = 1'b1;
          wr_addr_d  = addr_q[AW-1:0];
          resp_d     = ACK_BYTE;
        end else resp_d = regs_q[addr_q[AW-1:0]];
      end
      S_RESP: if (!tx_active_in) begin
        tx_dv_out = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: state_d = tx_done_in ? S_IDLE : state_q;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      cnt_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      regs_q     <= '{default: '0};
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      regs_q     <= regs_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign cfg_regs_out[8*i +: 8] = regs_q[i];
  end
  assign tx_data_out  = resp_q;
  assign wr_pulse_out = wr_pulse_q;
  assign wr_addr_out  = wr_addr_q;
  assign busy_out     = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed plus random frames checked against a register-array model of the command protocol.
module tb_uart_cmd_ctrl;
  localparam int NR = 16;
  localparam int TO = 16368;
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;
  logic clk = 0, rst = 0, rx_dv = 0, tx_active = 0, tx_done = 0;
  logic [7:0] rx_data = 0;
  logic tx_dv, wr_pulse, busy;
  logic [7:0] tx_data;
  logic [NR*8-1:0] cfg;
  logic [3:0] wr_addr;
  int n_assert = 0, n_fail = 0;
  int pulses = 0, txdvs = 0, exp_pulses = 0;
  logic [7:0] model [NR];
  logic [3:0] exp_wr_addr = 0;

  uart_cmd_ctrl #(.NUM_REGS(NR), .TIMEOUT_CLKS(TO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk_in(clk), .rst_in(rst), .rx_dv_in(rx_dv), .rx_data_in(rx_data),
    .tx_dv_out(tx_dv), .tx_data_out(tx_data), .tx_active_in(tx_active), .tx_done_in(tx_done),
    .cfg_regs_out(cfg), .wr_pulse_out(wr_pulse), .wr_addr_out(wr_addr), .busy_out(busy));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_pulse) pulses++;
    if (tx_dv) txdvs++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] flat();
    for (int k = 0; k < NR; k++) flat[8*k +: 8] = model[k];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_dv = 1;
    @(negedge clk);
    rx_dv = 0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int gap);
    logic [7:0] x = 0;
    foreach (q[i]) begin
      send_byte(q[i]);
      x ^= q[i];
`ifndef UART_CMD_CHECKSUM_EN
      if (i != q.size() - 1)
`endif
      repeat (gap) @(negedge clk);
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic finish_resp(input logic [7:0] exp, input int exp_lat, input string tag, input bit inject);
    int lat = 0;
    int dv0 = txdvs;
    while (!tx_dv && lat < 600) begin @(negedge clk); lat++; end
    chk({tag, " resp_seen"}, tx_dv, 1);
    if (exp_lat >= 0) chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, tx_data, exp);
    @(negedge clk);
    tx_active = 1;
    chk({tag, " one_strobe"}, tx_dv, 0);
    if (inject) send_byte(8'h57);
    repeat (3) @(negedge clk);
    chk({tag, " data_hold"}, tx_data, exp);
    tx_done = 1;
    tx_active = 0;
    @(negedge clk);
    tx_done = 0;
    chk({tag, " idle_after"}, busy, 0);
    chk({tag, " strobes"}, txdvs - dv0, 1);
    chk({tag, " wr_pulses"}, pulses, exp_pulses);
    chk({tag, " wr_addr"}, wr_addr, exp_wr_addr);
    chk({tag, " regs"}, cfg, flat());
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                          input int gap, input string tag, input bit inject);
    logic [7:0] exp;
    logic [7:0] fr[$];
    bit ok = int'(addr) < NR;
    if (cmd == 8'h57) begin
      fr = '{cmd, addr, data};
      exp = ok ? ACK : NAK;
      if (ok) begin model[addr[3:0]] = data; exp_pulses++; exp_wr_addr = addr[3:0]; end
      send_frame(fr, gap);
      finish_resp(exp, 1, tag, inject);
    end else if (cmd == 8'h52) begin
      fr = '{cmd, addr};
      exp = ok ? model[addr[3:0]] : NAK;
      send_frame(fr, gap);
      finish_resp(exp, 1, tag, inject);
    end else begin
      send_byte(cmd);
      finish_resp(NAK, 0, tag, inject);
    end
  endtask

  initial begin
    bit saw;
    int dv0, p0;
    logic [7:0] c;
    logic [7:0] fr[$];
    foreach (model[k]) model[k] = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst busy", busy, 0);
    chk("rst tx_dv", tx_dv, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst regs", cfg, 0);

    do_frame(8'h57, 8'h03, 8'hA5, 0, "write3", 0);
    chk("reg3 byte", cfg[31:24], 8'hA5);
    do_frame(8'h52, 8'h03, 8'h00, 0, "read3", 0);
    do_frame(8'h52, 8'h10, 8'h00, 0, "read_bad_addr", 0);
    do_frame(8'h57, 8'h20, 8'h11, 0, "write_bad_addr", 0);
    do_frame(8'h41, 8'h00, 8'h00, 0, "bad_cmd", 0);

    dv0 = txdvs;
    p0 = pulses;
    send_byte(8'h57);
    send_byte(8'h05);
    repeat (TO - 20) @(negedge clk);
    chk("timeout not_yet", busy, 1);
    repeat (30) @(negedge clk);
    chk("timeout idle", busy, 0);
    chk("timeout no_resp", txdvs - dv0, 0);
    chk("timeout no_write", pulses - p0, 0);
    do_frame(8'h52, 8'h05, 8'h00, 0, "read_after_timeout", 0);

    tx_active = 1;
    fr = '{8'h52, 8'h03};
    send_frame(fr, 0);
    saw = 0;
    repeat (500) begin @(negedge clk); saw |= tx_dv; end
    chk("backpressure held", saw, 0);
    chk("backpressure busy", busy, 1);
    tx_active = 0;
    #1;
    chk("backpressure release", tx_dv, 1);
    finish_resp(8'hA5, 0, "backpressure", 0);

    do_frame(8'h57, 8'h07, 8'h5A, 0, "drop_in_wait", 1);

    do_frame(8'h57, 8'h02, 8'h33, 0, "write2", 0);
    send_byte(8'h57);
    send_byte(8'h02);
    rst = 1;
    @(negedge clk);
    rst = 0;
    foreach (model[k]) model[k] = 0;
    exp_wr_addr = 0;
    chk("midrst regs", cfg, 0);
    chk("midrst busy", busy, 0);
    chk("midrst wr_addr", wr_addr, 0);
    do_frame(8'h52, 8'h02, 8'h00, 0, "read_after_rst", 0);

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h28);
    model[1] = 8'h7E; exp_pulses++; exp_wr_addr = 1;
    finish_resp(ACK, 1, "csum good", 0);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h99); send_byte(8'h29);
    finish_resp(NAK, 1, "csum bad", 0);
`endif

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1: c = 8'h57;
        2, 3: c = 8'h52;
        default: begin
          c = 8'($urandom);
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
        end
      endcase
      do_frame(c, ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NR + 3)),
               8'($urandom), $urandom_range(0, 5), $sformatf("rand%0d", n), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
